// File: rtl/queue_serializer.sv
// Pops one byte per period from an external queue and sends it LSB first as strobed serial slots, then idles GAP_CYCLES.
// Define QUEUE_SER_PARITY_EN to append an even-parity ninth slot; queue inputs are ignored while a byte is in flight.
module queue_serializer #(
  parameter int STROBE_CYCLES = 10,
  parameter int GAP_CYCLES    = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable_in,
  input  logic [3:0] len_in,
  input  logic [7:0] data_in,
  output logic       dequeue_out,
  output logic       data_out,
  output logic       write_out,
  output logic       busy_out
);

`ifdef QUEUE_SER_PARITY_EN
  localparam int NUM_BITS = 9;
`else
  localparam int NUM_BITS = 8;
`endif
  localparam int MAX_CYC = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       IDX_LAST    = 4'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    BIT_HI = 3'd2,
    BIT_LO = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             data_q, data_d;
  logic             armed_q;
  logic             cnt_done;
  logic             slot_bit;
`ifdef QUEUE_SER_PARITY_EN
  logic             par_q, par_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    cnt_done = 1'b0;
    case (state_q)
      BIT_HI, BIT_LO: cnt_done = (cnt_q == STROBE_LAST);
      GAP:            cnt_done = (cnt_q == GAP_LAST);
      default:        cnt_done = 1'b0;
    endcase
  end

  // armed_q holds off the first fetch for one full cycle after reset is released
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (armed_q && enable_in && (len_in != 4'd0)) state_d = FETCH;
      end
      FETCH: state_d = BIT_HI;
      BIT_HI: begin
        if (cnt_done) state_d = BIT_LO;
      end
      BIT_LO: begin
        if (cnt_done) state_d = (idx_q == IDX_LAST) ? GAP : BIT_HI;
      end
      GAP: begin
        if (cnt_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dequeue_out = 1'b0;
    write_out   = 1'b0;
    busy_out    = 1'b0;
    data_out    = 1'b0;
    if (!reset) begin
      dequeue_out = (state_q == FETCH);
      write_out   = (state_q == BIT_HI);
      busy_out    = (state_q != IDLE);
      data_out    = data_q;
    end
  end

  always_comb begin
    cnt_d   = '0;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    if ((state_d == state_q) && (state_q inside {BIT_HI, BIT_LO, GAP})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (state_q == FETCH) begin
      shreg_d = data_in;
      idx_d   = 4'd0;
    end else if ((state_q == BIT_LO) && (state_d == BIT_HI)) begin
      idx_d = idx_q + 4'd1;
    end
  end

`ifdef QUEUE_SER_PARITY_EN
  always_comb begin
    par_d = par_q;
    if (state_q == FETCH) par_d = ^data_in;
  end

  assign slot_bit = (idx_d == 4'd8) ? par_d : shreg_d[idx_d[2:0]];
`else
  assign slot_bit = shreg_d[idx_d[2:0]];
`endif

  // data_out only moves on entry to a new strobe-high slot
  always_comb begin
    data_d = data_q;
    if ((state_d == BIT_HI) && (state_q != BIT_HI)) data_d = slot_bit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= 4'd0;
      shreg_q <= 8'h00;
      data_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      armed_q <= 1'b1;
    end
  end

`ifdef QUEUE_SER_PARITY_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

endmodule

// File: tb/tb_queue_serializer.sv
// Scoreboard bench for queue_serializer: the stimulus acts as the byte queue and queues expectations, a monitor decodes the serial line.
// Build with QUEUE_SER_PARITY_EN defined to exercise the ninth parity slot.
module tb_queue_serializer;

  localparam int S = 10;
  localparam int G = 30;
`ifdef QUEUE_SER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int PERIOD = 1 + NB * 2 * S + G + 1;

  typedef struct {
    logic [7:0] b;
    logic       par;
  } byte_exp_t;

  logic       clock     = 1'b0;
  logic       reset     = 1'b1;
  logic       enable_in = 1'b0;
  logic [3:0] len_in    = 4'd0;
  logic [7:0] data_in   = 8'h00;
  logic       dequeue_out, data_out, write_out, busy_out;

  queue_serializer #(.STROBE_CYCLES(S), .GAP_CYCLES(G)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable_in   (enable_in),
    .len_in      (len_in),
    .data_in     (data_in),
    .dequeue_out (dequeue_out),
    .data_out    (data_out),
    .write_out   (write_out),
    .busy_out    (busy_out)
  );

  always #5 clock = ~clock;

  logic [7:0] src_q[$];
  int         exp_deq_q[$];
  byte_exp_t  exp_byte_q[$];
  logic [3:0] snap_val_q[$];
  string      snap_tag_q[$];
  bit         quiet       = 1'b0;
  bit         final_chk   = 1'b0;
  bit         pop_pending = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int         cyc = 0, last_deq = 0, hi_len = 0, lo_len = 0, nbits = 0, e = 0;
  logic [NB-1:0] rx = '0;
  logic       cur_bit = 1'b0, prev_deq = 1'b0, prev_write = 1'b0, prev_busy = 1'b0;
  bit         final_done = 1'b0;
  byte_exp_t  eb;
  string      st;
  logic [3:0] sv;

  always @(posedge clock) begin
    #1;
    cyc++;
    if (snap_val_q.size() > 0) begin
      sv = snap_val_q.pop_front();
      st = snap_tag_q.pop_front();
      chk(st, {dequeue_out, data_out, write_out, busy_out}, sv);
    end
    if (final_chk && !final_done) begin
      chk("dequeues_outstanding", exp_deq_q.size(), 0);
      chk("bytes_outstanding", exp_byte_q.size(), 0);
      final_done = 1'b1;
    end
    if (reset) begin
      nbits = 0;
    end else begin
      if (quiet) chk("quiet_outputs", {dequeue_out, write_out, busy_out}, 3'b000);
      if (dequeue_out) begin
        chk("deq_not_consecutive", prev_deq, 1'b0);
        chk("deq_expected", exp_deq_q.size() > 0, 1'b1);
        if (exp_deq_q.size() > 0) begin
          e = exp_deq_q.pop_front();
          if (e >= 0) chk("deq_spacing", cyc - last_deq, e);
        end
        last_deq = cyc;
      end
      if (!busy_out && prev_busy) chk("busy_after_fetch", cyc - last_deq, PERIOD - 1);
      if (write_out && !prev_write) begin
        if (nbits > 0) chk("strobe_lo_len", lo_len, S);
        cur_bit = data_out;
        if (nbits < NB) begin
          rx    = {data_out, rx[NB-1:1]};
          nbits = nbits + 1;
        end
        hi_len = 1;
      end else if (write_out) begin
        hi_len++;
      end else if (prev_write) begin
        chk("strobe_hi_len", hi_len, S);
        chk("bit_stable_fall", data_out, cur_bit);
        lo_len = 1;
      end else begin
        lo_len++;
        if ((nbits == NB) && (lo_len == S)) begin
          chk("bit_stable_end", data_out, cur_bit);
          chk("byte_expected", exp_byte_q.size() > 0, 1'b1);
          if (exp_byte_q.size() > 0) begin
            eb = exp_byte_q.pop_front();
            chk("byte_value", rx[7:0], eb.b);
`ifdef QUEUE_SER_PARITY_EN
            chk("parity_bit", rx[8], eb.par);
`endif
          end
          nbits = 0;
        end
      end
    end
    prev_deq   = dequeue_out;
    prev_write = write_out;
    prev_busy  = busy_out;
  end

  // ---------------- stimulus / queue model ----------------
  task automatic refresh();
    len_in  = 4'(src_q.size());
    data_in = (src_q.size() > 0) ? src_q[0] : 8'h00;
  endtask

  // the pop lands one negedge after FETCH so the byte is latched first
  task automatic tick();
    @(negedge clock);
    if (pop_pending && (src_q.size() > 0)) void'(src_q.pop_front());
    pop_pending = dequeue_out;
    refresh();
  endtask

  task automatic load(input logic [7:0] b);
    src_q.push_back(b);
    refresh();
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic par);
    byte_exp_t x;
    x.b   = b;
    x.par = par;
    exp_byte_q.push_back(x);
  endtask

  task automatic snap(input string tag, input logic [3:0] v);
    snap_tag_q.push_back(tag);
    snap_val_q.push_back(v);
  endtask

  task automatic wait_deq(input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (dequeue_out) break;
    end
  endtask

  initial begin
    repeat (3) tick();
    snap("reset_outputs", 4'b0000);
    tick();

    // single byte 0x80 straight out of reset
    load(8'h80);
    exp_deq_q.push_back(-1);
    expect_byte(8'h80, 1'b1);
    enable_in = 1'b1;
    reset     = 1'b0;
    snap("idle_after_reset", 4'b0000);
    wait_deq(20);
    repeat (PERIOD + 10) tick();

    // empty queue with enable high
    quiet = 1'b1;
    repeat (500) tick();
    quiet = 1'b0;

    // three queued bytes back to back
    exp_deq_q.push_back(-1);
    exp_deq_q.push_back(PERIOD);
    exp_deq_q.push_back(PERIOD);
    expect_byte(8'h81, 1'b0);
    expect_byte(8'h82, 1'b0);
    expect_byte(8'h83, 1'b1);
    load(8'h81);
    load(8'h82);
    load(8'h83);
    repeat (3 * PERIOD + 10) tick();

    // enable dropped mid-byte
    exp_deq_q.push_back(-1);
    expect_byte(8'h3C, 1'b0);
    load(8'h3C);
    load(8'hC3);
    wait_deq(20);
    repeat (20) tick();
    enable_in = 1'b0;
    repeat (PERIOD + 50) tick();
    exp_deq_q.push_back(-1);
    expect_byte(8'hC3, 1'b0);
    enable_in = 1'b1;
    repeat (PERIOD + 10) tick();

    // reset during strobe-high of bit 3 of 0x5A
    exp_deq_q.push_back(-1);
    load(8'h5A);
    wait_deq(20);
    repeat (62) tick();
    snap("bit3_strobe_high", 4'b0111);
    tick();
    reset = 1'b1;
    snap("abort_outputs", 4'b0000);
    repeat (3) tick();
    reset = 1'b0;
    snap("idle_after_abort", 4'b0000);
    repeat (300) tick();

    final_chk = 1'b1;
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/queue_serializer.md
QUEUE_SERIALIZER -- requirements
Module: queue_serializer

Interface
REQ-001 SHALL have parameter STROBE_CYCLES, default 10, clock cycles write_out is held high per bit and then held low per bit.
REQ-002 SHALL have parameter GAP_CYCLES, default 30, idle clock cycles inserted after each byte before the next fetch.
REQ-003 SHALL have port clock  input  1  single clock for the block; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable_in  input  1  permits fetching a new byte from the queue when high.
REQ-006 SHALL have port len_in  input  4  queue occupancy; connects to the queue's len_out.
REQ-007 SHALL have port data_in  input  8  queue head byte; connects to the queue's data_out.
REQ-008 SHALL have port dequeue_out  output  1  one-cycle pop strobe; connects to the queue's dequeue_in.
REQ-009 SHALL have port data_out  output  1  serial bit, stable for the full 2*STROBE_CYCLES bit slot.
REQ-010 SHALL have port write_out  output  1  bit strobe, high for the first STROBE_CYCLES of each bit slot.
REQ-011 SHALL have port busy_out  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, FETCH, BIT_HI, BIT_LO and GAP.
REQ-013 SHALL transition IDLE->FETCH on the first edge where enable_in=1 and len_in!=0; IDLE SHALL otherwise hold.
REQ-014 SHALL, in FETCH (exactly one cycle), drive dequeue_out=1, latch data_in into an 8-bit shift register, clear the bit index, and go to BIT_HI.
REQ-015 SHALL drive dequeue_out=1 only in FETCH, never for two consecutive cycles.
REQ-016 SHALL transmit LSB first: bit index k presents shift register bit k on data_out.
REQ-017 SHALL hold write_out=1 for exactly STROBE_CYCLES cycles in BIT_HI, then write_out=0 for exactly STROBE_CYCLES cycles in BIT_LO.
REQ-018 SHALL leave data_out unchanged across BIT_HI and BIT_LO of one bit, and update it only on entry to the next BIT_HI.
REQ-019 SHALL go BIT_LO->BIT_HI with index+1 after the last BIT_LO cycle while bits remain, else go BIT_LO->GAP.
REQ-020 SHALL stay in GAP for exactly GAP_CYCLES cycles with write_out=0, then return to IDLE.
REQ-021 SHALL make the byte period (FETCH to next possible FETCH) equal 1 + 8*2*STROBE_CYCLES + GAP_CYCLES + 1 cycles, i.e. 192 cycles at defaults.
REQ-022 SHALL ignore changes on len_in, data_in and enable_in outside IDLE/FETCH; a started byte always completes.
REQ-023 SHALL not fetch when len_in=0 (empty); dequeue_out stays 0.
REQ-024 SHALL size each cycle counter to hold max(STROBE_CYCLES, GAP_CYCLES)-1 with no wrap-around before terminal count.

Reset
REQ-025 SHALL, while reset=1, force state to IDLE and drive dequeue_out=0, data_out=0, write_out=0 and busy_out=0, with the shift register, counters and index cleared.
REQ-026 SHALL abort any byte in progress on reset without issuing a further dequeue_out; the popped byte is lost.
REQ-027 SHALL, after reset deasserts, wait at least one cycle in IDLE before a FETCH.

Configuration
REQ-028 SHALL, when macro QUEUE_SER_PARITY_EN is defined, append a ninth slot carrying even parity (XOR of the 8 data bits) after bit 7, with identical strobe timing.
REQ-029 SHALL make the byte period 1 + 9*2*STROBE_CYCLES + GAP_CYCLES + 1 cycles (212 at defaults) when QUEUE_SER_PARITY_EN is defined.
REQ-030 SHALL send exactly 8 bits per byte and contain no parity logic when QUEUE_SER_PARITY_EN is undefined.

Verification
REQ-031 SHALL cover: len_in=1, data_in=0x80, enable_in=1 -> one dequeue_out pulse, data_out sequence 0,0,0,0,0,0,0,1, each bit with 10 strobe-high and 10 strobe-low cycles, busy_out low 192 cycles after FETCH.
REQ-032 SHALL cover: len_in=0 with enable_in=1 for 500 cycles -> dequeue_out, write_out and busy_out stay 0.
REQ-033 SHALL cover: len_in=3 with heads 0x81, 0x82, 0x83 -> three dequeue_out pulses spaced exactly 192 cycles apart, bytes sent LSB first in order.
REQ-034 SHALL cover: reset=1 asserted during BIT_HI of bit 3 -> all outputs 0 on the next cycle, state IDLE, and no extra dequeue_out.
REQ-035 SHALL cover: enable_in dropped mid-byte with len_in=2 -> current byte completes, next FETCH only after enable_in returns to 1.
REQ-036 SHALL cover, with QUEUE_SER_PARITY_EN defined: data_in=0x80 -> ninth bit 1; data_in=0x81 -> ninth bit 0; byte period 212 cycles.
